// File: rtl/dds_phase_recover_pkg.sv
// Shared constants for the DDS chain: Q3.13 angle constants, the CORDIC
// gain-compensation factor, the FSM state type and the arctangent ROM
// used by both the rotation-mode and vectoring-mode CORDICs.
package dds_phase_recover_pkg;

    // Width of the angle accumulator; leaves room for +/-PI plus the
    // transient overshoot of the micro-rotations.
    localparam int ZW = 18;

    // Q3.13 radians, held at ZW bits so 2PI is positive.
    localparam logic signed [ZW-1:0] PI2_Z    = 18'sd12868;
    localparam logic signed [ZW-1:0] PI_Z     = 18'sd25736;
    localparam logic signed [ZW-1:0] TWO_PI_Z = 18'sd51472;

    // 1/K = 0.60725 in Q0.15.
    localparam logic [14:0] MAG_GAIN = 15'd19898;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FOLD    = 2'd1,
        ST_ITERATE = 2'd2,
        ST_DIFF    = 2'd3
    } state_t;

    // round(atan(2^-i) * 8192)
    function automatic logic [12:0] atan_tab(input logic [3:0] idx);
        logic [12:0] val;
        case (idx)
            4'd0:    val = 13'd6434;
            4'd1:    val = 13'd3798;
            4'd2:    val = 13'd2007;
            4'd3:    val = 13'd1019;
            4'd4:    val = 13'd511;
            4'd5:    val = 13'd256;
            4'd6:    val = 13'd128;
            4'd7:    val = 13'd64;
            4'd8:    val = 13'd32;
            4'd9:    val = 13'd16;
            4'd10:   val = 13'd8;
            4'd11:   val = 13'd4;
            4'd12:   val = 13'd2;
            4'd13:   val = 13'd1;
            default: val = 13'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/dds_phase_recover_cordic_vector_iter.sv
// Registered vectoring-mode CORDIC datapath. One micro-rotation per clock
// while step_en is high; load presets x/y/z with the folded vector.
// The x_out port exists only when DDS_PHASE_RECOVER_MAG_EN is defined.
module cordic_vector_iter
    import dds_phase_recover_pkg::*;
#(
    parameter int IW = 18
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic signed [IW-1:0] x_init,
    input  logic signed [IW-1:0] y_init,
    input  logic signed [ZW-1:0] z_init,
    input  logic                 step_en,
    input  logic [3:0]           step_idx,
`ifdef DDS_PHASE_RECOVER_MAG_EN
    output logic signed [IW-1:0] x_out,
`endif
    output logic signed [ZW-1:0] z_out
);

    logic signed [IW-1:0] x_q, x_d;
    logic signed [IW-1:0] y_q, y_d;
    logic signed [ZW-1:0] z_q, z_d;
    logic signed [IW-1:0] x_sh, y_sh;
    logic signed [ZW-1:0] atan_ext;

    // Next x/y/z: preset on load, otherwise drive y toward zero using the
    // pre-step x and y for both cross terms.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        x_sh     = x_q >>> step_idx;
        y_sh     = y_q >>> step_idx;
        atan_ext = {{(ZW-13){1'b0}}, atan_tab(step_idx)};
        if (load) begin
            x_d = x_init;
            y_d = y_init;
            z_d = z_init;
        end else if (step_en) begin
            if (!y_q[IW-1]) begin
                x_d = x_q + y_sh;
                y_d = y_q - x_sh;
                z_d = z_q + atan_ext;
            end else begin
                x_d = x_q - y_sh;
                y_d = y_q + x_sh;
                z_d = z_q - atan_ext;
            end
        end
    end

    // Datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
        end
    end

`ifdef DDS_PHASE_RECOVER_MAG_EN
    assign x_out = x_q;
`endif
    assign z_out = z_q;

endmodule

// File: rtl/dds_phase_recover.sv
// Phase recovery for the DDS chain: captures an I/Q pair, folds it into the
// right half-plane, runs ITER vectoring CORDIC steps to get the angle, and
// differences successive angles to recover the tuning increment.
// Optional magnitude output is enabled with DDS_PHASE_RECOVER_MAG_EN.
module dds_phase_recover
    import dds_phase_recover_pkg::*;
#(
    parameter int ITER = 14,
    parameter int IW   = 18
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    input  logic        update,
    output logic [15:0] angle,
    output logic [15:0] increment,
    output logic        ready
`ifdef DDS_PHASE_RECOVER_MAG_EN
    ,
    output logic [15:0] mag
`endif
);

    localparam logic [3:0] LAST_STEP = 4'(ITER - 1);

    state_t      state_q, state_d;
    logic [15:0] ix_q, ix_d;
    logic [15:0] iy_q, iy_d;
    logic [3:0]  step_q, step_d;
    logic [15:0] angle_q, angle_d;
    logic [15:0] inc_q, inc_d;
    logic [15:0] prev_q, prev_d;
    logic        first_q, first_d;
    logic        ready_q, ready_d;

    logic                 iter_load, iter_step;
    logic signed [IW-1:0] x_ext, y_ext;
    logic signed [IW-1:0] fold_x, fold_y;
    logic signed [ZW-1:0] fold_z;
    logic signed [ZW-1:0] z_fin;
    logic signed [ZW-1:0] diff_raw, diff_wrap;

`ifdef DDS_PHASE_RECOVER_MAG_EN
    logic [15:0]          mag_q, mag_d;
    logic signed [IW-1:0] x_fin;
    logic [IW-2:0]        x_mag;
    logic [IW+13:0]       mag_prod;
    logic [IW-2:0]        mag_scaled;
`endif

    cordic_vector_iter #(
        .IW(IW)
    ) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (iter_load),
        .x_init   (fold_x),
        .y_init   (fold_y),
        .z_init   (fold_z),
        .step_en  (iter_step),
        .step_idx (step_q),
`ifdef DDS_PHASE_RECOVER_MAG_EN
        .x_out    (x_fin),
`endif
        .z_out    (z_fin)
    );

    // Fold the captured sample into x >= 0 and seed z with the rotation used.
    always_comb begin
        x_ext = {{(IW-16){ix_q[15]}}, ix_q};
        y_ext = {{(IW-16){iy_q[15]}}, iy_q};
        if (x_ext[IW-1]) begin
            fold_x = -x_ext;
            fold_y = -y_ext;
            fold_z = iy_q[15] ? -PI_Z : PI_Z;
        end else begin
            fold_x = x_ext;
            fold_y = y_ext;
            fold_z = '0;
        end
    end

    // Angle difference wrapped back into (-PI, PI].
    always_comb begin
        diff_raw = z_fin - {{(ZW-16){prev_q[15]}}, prev_q};
        if (diff_raw > PI_Z) begin
            diff_wrap = diff_raw - TWO_PI_Z;
        end else if (diff_raw <= -PI_Z) begin
            diff_wrap = diff_raw + TWO_PI_Z;
        end else begin
            diff_wrap = diff_raw;
        end
    end

`ifdef DDS_PHASE_RECOVER_MAG_EN
    // Gain-compensated magnitude, saturated to 16 bits.
    always_comb begin
        x_mag      = x_fin[IW-1] ? '0 : x_fin[IW-2:0];
        mag_prod   = (IW+14)'(x_mag) * (IW+14)'(MAG_GAIN);
        mag_scaled = mag_prod[IW+13:15];
        if (|mag_scaled[IW-2:16]) begin
            mag_d = 16'hFFFF;
        end else begin
            mag_d = mag_scaled[15:0];
        end
    end
`endif

    // Sequencer: next state, capture, iteration control and result update.
    always_comb begin
        state_d   = state_q;
        ix_d      = ix_q;
        iy_d      = iy_q;
        step_d    = step_q;
        angle_d   = angle_q;
        inc_d     = inc_q;
        prev_d    = prev_q;
        first_d   = first_q;
        ready_d   = ready_q;
        iter_load = 1'b0;
        iter_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (update) begin
                    ix_d    = in_x;
                    iy_d    = in_y;
                    ready_d = 1'b0;
                    state_d = ST_FOLD;
                end
            end
            ST_FOLD: begin
                iter_load = 1'b1;
                step_d    = 4'd0;
                state_d   = ST_ITERATE;
            end
            ST_ITERATE: begin
                iter_step = 1'b1;
                if (step_q == LAST_STEP) begin
                    state_d = ST_DIFF;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            ST_DIFF: begin
                // -PI is reported as +PI so the output range is (-PI, PI].
                angle_d = (z_fin == -PI_Z) ? PI_Z[15:0] : z_fin[15:0];
                inc_d   = first_q ? 16'd0 : diff_wrap[15:0];
                first_d = 1'b0;
                prev_d  = z_fin[15:0];
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and result registers; reset aborts any computation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ix_q    <= '0;
            iy_q    <= '0;
            step_q  <= '0;
            angle_q <= '0;
            inc_q   <= '0;
            prev_q  <= '0;
            first_q <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ix_q    <= ix_d;
            iy_q    <= iy_d;
            step_q  <= step_d;
            angle_q <= angle_d;
            inc_q   <= inc_d;
            prev_q  <= prev_d;
            first_q <= first_d;
            ready_q <= ready_d;
        end
    end

`ifdef DDS_PHASE_RECOVER_MAG_EN
    // Magnitude register, refreshed only when a result is produced.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag_q <= '0;
        end else if (state_q == ST_DIFF) begin
            mag_q <= mag_d;
        end
    end

    assign mag = mag_q;
`endif

    assign angle     = angle_q;
    assign increment = inc_q;
    assign ready     = ready_q;

endmodule
